// File: rtl/chirp_dds_pkg.sv
// Shared widths, LFSR constants and payload types for the chirp DDS.
package chirp_pkg;

    localparam int unsigned PINC_W = 24;
    localparam int unsigned LUT_AW = 10;
    localparam int unsigned OUT_W  = 14;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SAMP_W = 16;
    localparam int unsigned FOLD_W = 2 + LUT_AW;
    localparam int unsigned DITH_W = PINC_W - FOLD_W;

    localparam int unsigned         LFSR_W    = 16;
    localparam logic [LFSR_W-1:0]   LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0]   LFSR_TAPS = 16'hB400;

    localparam real PI = 3.14159265358979323846;

    typedef logic signed [SAMP_W-1:0] sample_t;

    typedef struct packed {
        logic              valid;
        logic              neg;
        logic [LUT_AW-1:0] addr;
    } fold_t;

endpackage

// File: rtl/chirp_dds_if.sv
// Phase-increment input stream and sample output stream of the chirp DDS.
interface chirp_dds_if;
    import chirp_pkg::*;

    logic [PINC_W-1:0] s_axis_pinc_tdata;
    logic              s_axis_pinc_tvalid;
    sample_t           m_axis_tdata;
    logic              m_axis_tvalid;
    logic              chirp_done;
    logic [CNT_W-1:0]  samp_count;

    modport master (
        output s_axis_pinc_tdata, s_axis_pinc_tvalid,
        input  m_axis_tdata, m_axis_tvalid, chirp_done, samp_count
    );

    modport slave (
        input  s_axis_pinc_tdata, s_axis_pinc_tvalid,
        output m_axis_tdata, m_axis_tvalid, chirp_done, samp_count
    );

endinterface

// File: rtl/chirp_dds_qlut.sv
// Quarter-wave sine ROM with half-bin offset, one-cycle registered read.
module chirp_dds_qlut #(
    parameter int unsigned LUT_AW = 10,
    parameter int unsigned OUT_W  = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [LUT_AW-1:0] addr,
    output logic [OUT_W-2:0]  mag_q
);
    import chirp_pkg::PI;

    localparam int unsigned DEPTH = 2 ** LUT_AW;

    function automatic logic [OUT_W-2:0] lut_val(input int i);
        real amp;
        real x;
        amp = real'((2 ** (OUT_W - 1)) - 1);
        x   = amp * $sin(PI / 2.0 * (real'(i) + 0.5) / real'(DEPTH));
        return (OUT_W-1)'($rtoi(x + 0.5));
    endfunction

    logic [OUT_W-2:0] rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom[gi] = lut_val(gi);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mag_q <= '0;
        else       mag_q <= rom[addr];
    end

endmodule

// File: rtl/chirp_dds.sv
// Chirp DDS: phase accumulator cleared per chirp, quadrant fold, quarter-wave LUT.
// Optional phase dither LFSR enabled by defining CHIRP_DDS_DITHER_EN.
module chirp_dds
    import chirp_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    chirp_dds_if.slave bus
);

`ifdef CHIRP_DDS_DITHER_EN
    localparam int unsigned PH1_W = PINC_W;
`else
    localparam int unsigned PH1_W = FOLD_W;
`endif

    logic [PINC_W-1:0] acc_q,   acc_d;
    logic [PH1_W-1:0]  ph_s1_q, ph_s1_d;
    logic              v_s1_q,  v_s1_d;
    fold_t             fold_s2_q, fold_s2_d;
    logic              v_s3_q,  v_s3_d;
    logic              neg_s3_q, neg_s3_d;
    sample_t           tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              done_q,  done_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [FOLD_W-1:0] ph_fold;
    logic [OUT_W-2:0]  lut_mag;
    sample_t           mag_ext;

    // Stage 1: accumulator restarts at phase 0 whenever the input stream drops
    always_comb begin
        acc_d   = bus.s_axis_pinc_tvalid ? acc_q + bus.s_axis_pinc_tdata : '0;
        ph_s1_d = acc_q[PINC_W-1 -: PH1_W];
        v_s1_d  = bus.s_axis_pinc_tvalid;
    end

`ifdef CHIRP_DDS_DITHER_EN
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [PINC_W-1:0] ph_dith;

    always_comb begin
        lfsr_d = lfsr_q;
        if (v_s1_q) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end

    assign ph_dith = ph_s1_q + PINC_W'(lfsr_q[DITH_W-1:0]);
    assign ph_fold = ph_dith[PINC_W-1 -: FOLD_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign ph_fold = ph_s1_q;
`endif

    // Stage 2: mirror odd quadrants, negate the lower half-wave
    always_comb begin
        fold_s2_d.valid = v_s1_q;
        fold_s2_d.neg   = ph_fold[FOLD_W-1];
        fold_s2_d.addr  = ph_fold[FOLD_W-2] ? ~ph_fold[LUT_AW-1:0] : ph_fold[LUT_AW-1:0];
    end

    chirp_dds_qlut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_qlut (
        .clk   (clk),
        .rstn  (rstn),
        .addr  (fold_s2_q.addr),
        .mag_q (lut_mag)
    );

    assign mag_ext = sample_t'({{(SAMP_W-OUT_W+1){1'b0}}, lut_mag});

    // Stages 3-4: align side-band with the ROM, sign the sample, track chirp length
    always_comb begin
        v_s3_d   = fold_s2_q.valid;
        neg_s3_d = fold_s2_q.neg;
        tvalid_d = v_s3_q;
        tdata_d  = '0;
        if (v_s3_q) tdata_d = neg_s3_q ? -mag_ext : mag_ext;
        done_d   = tvalid_q & ~v_s3_q;
        cnt_d    = cnt_q;
        if (v_s3_q) begin
            if (!tvalid_q)        cnt_d = CNT_W'(1);
            else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q     <= '0;
            ph_s1_q   <= '0;
            v_s1_q    <= 1'b0;
            fold_s2_q <= '0;
            v_s3_q    <= 1'b0;
            neg_s3_q  <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            ph_s1_q   <= ph_s1_d;
            v_s1_q    <= v_s1_d;
            fold_s2_q <= fold_s2_d;
            v_s3_q    <= v_s3_d;
            neg_s3_q  <= neg_s3_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.chirp_done    = done_q;
    assign bus.samp_count    = cnt_q;

endmodule

// File: tb/tb_chirp_dds.sv
// Directed bench for chirp_dds: cycle-by-cycle reference model plus hand-computed samples.
module tb_chirp_dds;
    import chirp_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    chirp_dds_if bus ();

    chirp_dds u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        bit v;
        int s;
    } exp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        pipe[$];
    logic [23:0] m_acc;
    bit          m_prev_v;
    int          m_cnt;
    int          done_seen;
    int          cap[$];
    int          done_cnt[$];

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    function automatic int model_samp(input logic [23:0] ph);
        logic [1:0] qd;
        logic [9:0] a;
        real        x;
        int         mag;
        qd = ph[23:22];
        a  = ph[21:12];
        if (qd[0]) a = ~a;
        x   = 8191.0 * $sin(3.14159265358979 * (real'(a) + 0.5) / 2048.0);
        mag = $rtoi(x + 0.5);
        return qd[1] ? -mag : mag;
    endfunction

    task automatic model_reset();
        exp_t e;
        m_acc    = '0;
        m_prev_v = 1'b0;
        m_cnt    = 0;
        pipe.delete();
        e.v = 1'b0;
        e.s = 0;
        repeat (3) pipe.push_back(e);
    endtask

    // Called #1 after a posedge; drives one input cycle and checks the resulting output.
    task automatic step(input bit v, input logic [23:0] d);
        exp_t e;
        bus.s_axis_pinc_tvalid = v;
        bus.s_axis_pinc_tdata  = d;
        e.v = v;
        e.s = v ? model_samp(m_acc) : 0;
        pipe.push_back(e);
        m_acc = v ? m_acc + d : '0;
        @(posedge clk);
        #1;
        e = pipe.pop_front();
        check("tvalid", int'(bus.m_axis_tvalid), int'(e.v));
        check("tdata", int'(bus.m_axis_tdata), e.s);
        check("chirp_done", int'(bus.chirp_done), int'(m_prev_v && !e.v));
        if (e.v) m_cnt = m_prev_v ? ((m_cnt == 65535) ? m_cnt : m_cnt + 1) : 1;
        check("samp_count", int'(bus.samp_count), m_cnt);
        if (bus.chirp_done) begin
            done_seen++;
            done_cnt.push_back(int'(bus.samp_count));
        end
        if (bus.m_axis_tvalid) cap.push_back(int'(bus.m_axis_tdata));
        m_prev_v = e.v;
    endtask

    task automatic clear_obs();
        done_seen = 0;
        cap.delete();
        done_cnt.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, limit 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int t2[4];
        int t6[4];
        t2 = '{6, 8191, -6, -8191};
        t6 = '{6, -6, -6, -6};

        bus.s_axis_pinc_tvalid = 1'b0;
        bus.s_axis_pinc_tdata  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset
        clear_obs();
        repeat (10) step(1'b0, 24'd0);
        check("idle_done_count", done_seen, 0);

        // Quarter-turn increment, 8 samples
        clear_obs();
        repeat (8) step(1'b1, 24'h400000);
        repeat (6) step(1'b0, 24'd0);
        check("qturn_len", cap.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("qturn_s%0d", i), cap[i], t2[i % 4]);
        check("qturn_done", done_seen, 1);
        check("qturn_count", int'(bus.samp_count), 8);

        // Two chirps separated by a one-cycle gap
        clear_obs();
        repeat (20) step(1'b1, 24'd5167);
        step(1'b0, 24'd0);
        repeat (20) step(1'b1, 24'd5570);
        repeat (6) step(1'b0, 24'd0);
        check("gap_len", cap.size(), 40);
        check("gap_second_first", cap[20], 6);
        check("gap_done", done_seen, 2);
        check("gap_count0", done_cnt[0], 20);
        check("gap_count1", done_cnt[1], 20);

        // Asynchronous reset in the middle of a chirp
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 24'd5167);
            if (cap.size() == 5) break;
        end
        check("rst_reached_s5", cap.size(), 5);
        rstn = 1'b0;
        bus.s_axis_pinc_tvalid = 1'b0;
        #1;
        check("rst_tvalid", int'(bus.m_axis_tvalid), 0);
        check("rst_tdata", int'(bus.m_axis_tdata), 0);
        check("rst_done", int'(bus.chirp_done), 0);
        check("rst_count", int'(bus.samp_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        clear_obs();
        repeat (4) step(1'b0, 24'd0);
        check("rst_no_done", done_seen, 0);
        repeat (8) step(1'b1, 24'h400000);
        repeat (6) step(1'b0, 24'd0);
        check("rst_new_len", cap.size(), 8);
        check("rst_new_first", cap[0], 6);

        // Linear sweep 5167..5570, 7 samples per step
        clear_obs();
        for (int p = 5167; p <= 5570; p++) repeat (7) step(1'b1, 24'(p));
        repeat (6) step(1'b0, 24'd0);
        check("sweep_len", cap.size(), 2828);
        check("sweep_count", int'(bus.samp_count), 2828);
        check("sweep_done", done_seen, 1);

        // Negative increment wrapping into the fourth quadrant
        clear_obs();
        repeat (4) step(1'b1, 24'hFFFFFF);
        repeat (6) step(1'b0, 24'd0);
        check("wrap_len", cap.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("wrap_s%0d", i), cap[i], t6[i]);
        check("wrap_count", int'(bus.samp_count), 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
